laby5_core: RTL and testbench

//  Single-bit, mode-selectable signal conditioner with registered outputs.
//  i_vin is processed by one of four functions chosen by {i_a,i_b}.

---
 rtl/laby5_core.sv | 53 +++++
 tb/tb_laby5_core.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/laby5_core.sv
// Single-bit signal conditioner. {i_a,i_b} selects buffer, inverter, one-cycle delay or T flip-flop.
// o_vout is registered, and o_d pulses for one cycle whenever o_vout changes.
module laby5_core (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_vin,
    input  logic i_b,
    input  logic i_a,
    output logic o_vout,
    output logic o_d
);

    logic [1:0] w_mode;
    logic       w_vNxt;
    logic       r_vinQ;
    logic       r_togQ;
    logic       r_vout;
    logic       r_d;

    assign w_mode = {i_a, i_b};

    always_comb begin
        w_vNxt = i_vin;
        case (w_mode)
            2'b00:   w_vNxt = i_vin;
            2'b01:   w_vNxt = ~i_vin;
            2'b10:   w_vNxt = r_vinQ;
            2'b11:   w_vNxt = r_togQ ^ i_vin;
            default: w_vNxt = i_vin;
        endcase
    end

    // The toggle state only advances in mode 11, so re-entering that mode resumes from the held value.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vinQ <= 1'b0;
            r_togQ <= 1'b0;
            r_vout <= 1'b0;
            r_d    <= 1'b0;
        end else begin
            r_vinQ <= i_vin;
            if (w_mode == 2'b11) begin
                r_togQ <= r_togQ ^ i_vin;
            end
            r_vout <= w_vNxt;
            r_d    <= w_vNxt ^ r_vout;
        end
    end

    assign o_vout = r_vout;
    assign o_d    = r_d;

endmodule

// File: tb/tb_laby5_core.sv
// Self-checking bench for laby5_core: directed literal checks plus a randomized run.
// A behavioural model is compared against the DUT on every falling clock edge.
module tb_laby5_core;

    logic clk;
    logic rstN;
    logic vin;
    logic selA;
    logic selB;
    logic vout;
    logic dFlag;

    int checks = 0;
    int errors = 0;

    // Behavioural model state: previous input, count of toggles taken, expected outputs.
    logic mVout;
    logic mD;
    logic mPrev;
    int   mTogCount;

    laby5_core dut (
        .i_clk  (clk),
        .i_rst_n(rstN),
        .i_vin  (vin),
        .i_b    (selB),
        .i_a    (selA),
        .o_vout (vout),
        .o_d    (dFlag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The model computes each mode's result from its definition: copy, complement, input from one edge earlier, or the parity of all toggle requests so far.
    always @(posedge clk or negedge rstN) begin
        logic nxt;
        if (!rstN) begin
            mVout     = 1'b0;
            mD        = 1'b0;
            mPrev     = 1'b0;
            mTogCount = 0;
        end else begin
            case ({selA, selB})
                2'b00:   nxt = vin;
                2'b01:   nxt = !vin;
                2'b10:   nxt = mPrev;
                default: nxt = ((mTogCount + int'(vin)) % 2) == 1;
            endcase
            if ({selA, selB} == 2'b11 && vin) mTogCount++;
            mD    = (nxt != mVout);
            mVout = nxt;
            mPrev = vin;
        end
    end

    task automatic checkOutput(input string name, input logic expVout, input logic expD);
        checks++;
        if (vout !== expVout) begin
            errors++;
            $display("[TB] FAIL %s o_vout: got %b expected %b at %0t", name, vout, expVout, $time);
        end
        checks++;
        if (dFlag !== expD) begin
            errors++;
            $display("[TB] FAIL %s o_d: got %b expected %b at %0t", name, dFlag, expD, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic a, input logic b);
        vin  = v;
        selA = a;
        selB = b;
    endtask

    always @(negedge clk) begin
        checkOutput("model", mVout, mD);
    end

    // Assert reset in the middle of a cycle, hold it across an edge, release on a falling edge.
    task automatic pulseReset();
        #2 rstN = 1'b0;
        #1 checkOutput("reset_async", 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_hold", 1'b0, 1'b0);
        rstN = 1'b1;
    endtask

    initial begin
        rstN = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_initial", 1'b0, 1'b0);
        rstN = 1'b1;

        // Mode 00: buffer.
        applyStimulus(1'b0, 1'b0, 1'b0);
        @(negedge clk); checkOutput("buf_low", 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        @(negedge clk); checkOutput("buf_rise", 1'b1, 1'b1);
        @(negedge clk); checkOutput("buf_hold", 1'b1, 1'b0);

        // Reset while o_vout is high.
        pulseReset();

        // Mode 01: inverter.
        applyStimulus(1'b0, 1'b0, 1'b1);
        @(negedge clk); checkOutput("inv_zero", 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        @(negedge clk); checkOutput("inv_one", 1'b0, 1'b1);

        // Mode 10: two-cycle delay of a single-cycle pulse. The previous input was 1.
        applyStimulus(1'b0, 1'b1, 1'b0);
        @(negedge clk); checkOutput("dly_flush1", 1'b1, 1'b1);
        @(negedge clk); checkOutput("dly_flush2", 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        @(negedge clk); checkOutput("dly_pulse_in", 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        @(negedge clk); checkOutput("dly_pulse_out", 1'b1, 1'b1);
        @(negedge clk); checkOutput("dly_pulse_end", 1'b0, 1'b1);
        @(negedge clk); checkOutput("dly_idle", 1'b0, 1'b0);

        // Mode 11: T flip-flop running from reset.
        applyStimulus(1'b1, 1'b1, 1'b1);
        pulseReset();
        @(negedge clk); checkOutput("tff_1", 1'b1, 1'b1);
        @(negedge clk); checkOutput("tff_2", 1'b0, 1'b1);
        @(negedge clk); checkOutput("tff_3", 1'b1, 1'b1);
        @(negedge clk); checkOutput("tff_4", 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        @(negedge clk); checkOutput("tff_hold", 1'b0, 1'b0);

        // The toggle state is held through mode 00 and resumes when mode 11 returns.
        applyStimulus(1'b1, 1'b1, 1'b1);
        @(negedge clk); checkOutput("tff_set", 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        @(negedge clk); checkOutput("resume_buf", 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        @(negedge clk); checkOutput("resume_buf2", 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        @(negedge clk); checkOutput("resume_held", 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        @(negedge clk); checkOutput("resume_toggle", 1'b0, 1'b1);

        // Sweep all eight input combinations, one 10 ns cycle each.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] combo;
            combo = 3'(i);
            applyStimulus(combo[2], combo[0], combo[1]);
            @(negedge clk);
        end

        // Randomized run with occasional mid-cycle resets.
        for (int n = 0; n < 600; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 49) == 0) begin
                pulseReset();
            end else begin
                @(negedge clk);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
